// File: rtl/seq_divider32_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider32_if
// Description : Handshake and data bundle for the seq_divider32 divider.
//               master : the requester. It drives start and the operands, and
//                        receives busy, done and the results.
//               slave  : the divider itself.
//               signed_mode is present only when SIGNED_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider32_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
   logic             signed_mode;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
`ifdef SIGNED_DIV_EN
      output signed_mode,
`endif
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
`ifdef SIGNED_DIV_EN
      input  signed_mode,
`endif
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/seq_divider32.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider32
// Description : Multi-cycle restoring divider. It performs one trial
//               subtraction per clock and produces WIDTH quotient bits in
//               WIDTH cycles. The borrow convention is carry = 1 means
//               no borrow.
//               The optional feature is enabled by the macro SIGNED_DIV_EN.
//               It adds bus.signed_mode, which selects two's complement
//               operands. The core divides the magnitudes, and the signs are
//               applied to the results as the FSM enters FIN.
// Ports       : clk    - rising-edge clock
//               rst_n  - synchronous active-low reset
//               bus    - seq_divider32_if.slave:
//                        start, dividend, divisor, [signed_mode] in;
//                        busy, done, quotient, remainder, div_by_zero out
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider32 #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_divider32_if.slave     bus
);

   localparam int                 c_cnt_w    = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_dvd;    // dividend bits shift out at the MSB, quotient bits shift in at the LSB
   logic [WIDTH-1:0]   r_dsr;
   logic [WIDTH-1:0]   r_p;      // partial remainder, always < r_dsr
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_rem;
   logic               r_dbz;
`ifdef SIGNED_DIV_EN
   logic               r_neg_q;
   logic               r_neg_r;
`endif

   // The shifted partial remainder keeps the bit that leaves r_p.
   // r_p < r_dsr holds, but for divisors above 2^(WIDTH-1) the shifted value
   // can need WIDTH+1 bits.
   logic [WIDTH:0]     w_shift;
   logic               w_carry;
   logic [WIDTH-1:0]   w_p_next;
   logic [WIDTH-1:0]   w_q_next;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;

   assign w_shift  = {r_p, r_dvd[WIDTH-1]};
   assign w_carry  = (w_shift >= {1'b0, r_dsr});
   // When the trial succeeds, the difference is below r_dsr.
   // It therefore fits in WIDTH bits, so a WIDTH-bit subtract is exact.
   assign w_p_next = w_carry ? (w_shift[WIDTH-1:0] - r_dsr) : w_shift[WIDTH-1:0];
   assign w_q_next = {r_dvd[WIDTH-2:0], w_carry};

`ifdef SIGNED_DIV_EN
   logic w_neg_a;
   logic w_neg_b;
   assign w_neg_a = bus.signed_mode & bus.dividend[WIDTH-1];
   assign w_neg_b = bus.signed_mode & bus.divisor[WIDTH-1];
   assign w_a_mag = w_neg_a ? (-bus.dividend) : bus.dividend;
   assign w_b_mag = w_neg_b ? (-bus.divisor)  : bus.divisor;
`else
   assign w_a_mag = bus.dividend;
   assign w_b_mag = bus.divisor;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_p     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            // FIN accepts start the same way IDLE does, which allows back-to-back operations.
            S_IDLE, S_FIN: begin
               if (bus.start) begin
                  if (bus.divisor != '0) begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                     r_dvd   <= w_a_mag;
                     r_dsr   <= w_b_mag;
                     r_p     <= '0;
                     r_cnt   <= c_cnt_init;
`ifdef SIGNED_DIV_EN
                     r_neg_q <= w_neg_a ^ w_neg_b;
                     r_neg_r <= w_neg_a;
`endif
                  end else begin
                     // Divide by zero: the raw dividend is the remainder in both modes.
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                     r_quot  <= '1;
                     r_rem   <= bus.dividend;
                     r_dbz   <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end

            S_RUN: begin
               r_p   <= w_p_next;
               r_dvd <= w_q_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= S_FIN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
                  // Negating the magnitude 2^(WIDTH-1) gives the same value.
                  // So most-negative / -1 needs no special handling.
                  r_quot  <= r_neg_q ? (-w_q_next) : w_q_next;
                  r_rem   <= r_neg_r ? (-w_p_next) : w_p_next;
`else
                  r_quot  <= w_q_next;
                  r_rem   <= w_p_next;
`endif
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider32.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider32
// Description : Self-checking bench for seq_divider32. It runs directed and
//               random divisions and compares each one with a reference model
//               built from plain / and % arithmetic. The signed cases are
//               enabled when SIGNED_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider32;

   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_divider32_if #(.WIDTH(W)) u_if ();

   seq_divider32 #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: the plain arithmetic definition of the divider results.
   task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      logic [W-1:0] most_neg;
      most_neg = '0;
      most_neg[W-1] = 1'b1;
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
      end else if (s) begin
         z = 1'b0;
         if (a == most_neg && b == '1) begin
            q = most_neg; r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endtask

   function automatic logic eff_signed(input logic s);
`ifdef SIGNED_DIV_EN
      return s;
`else
      return 1'b0 & s;
`endif
   endfunction

   // Presents an operation for one cycle and ends in cycle 1. The operands are
   // then scrambled, because the divider must have captured them already.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      u_if.start    = 1'b1;
      u_if.dividend = a;
      u_if.divisor  = b;
`ifdef SIGNED_DIV_EN
      u_if.signed_mode = s;
`endif
      tick();
      u_if.start    = 1'b0;
      u_if.dividend = $urandom;
      u_if.divisor  = $urandom;
`ifdef SIGNED_DIV_EN
      u_if.signed_mode = 1'($urandom_range(0, 1));
`endif
   endtask

   // Watches cycles c0.. for done, with a bounded wait. Returns with time in the done cycle.
   task automatic wait_done(input int c0, output int dc, output int bc);
      dc = -1;
      bc = 0;
      for (int c = c0; c <= 60; c++) begin
         if (u_if.busy) bc++;
         if (u_if.done) begin
            dc = c;
            break;
         end
         tick();
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s);
      logic [W-1:0] q, r;
      logic         z;
      ref_div(a, b, eff_signed(s), q, r, z);
      chk({tag, "_quot"}, u_if.quotient, q);
      chk({tag, "_rem"},  u_if.remainder, r);
      chk({tag, "_dbz"},  W'(u_if.div_by_zero), W'(z));
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input bit idle_after);
      int dc, bc;
      issue(a, b, s);
      wait_done(1, dc, bc);
      chk({tag, "_done_cycle"}, W'(dc), (b == '0) ? W'(1) : W'(W + 1));
      chk({tag, "_busy_cycles"}, W'(bc), (b == '0) ? W'(0) : W'(W));
      check_result(tag, a, b, s);
      if (idle_after) begin
         tick();
         chk({tag, "_done_pulse"}, W'(u_if.done), W'(0));
         chk({tag, "_busy_after"}, W'(u_if.busy), W'(0));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, bc, cnt;
      logic [W-1:0] a, b;
      logic s;

      u_if.start    = 1'b0;
      u_if.dividend = '0;
      u_if.divisor  = '0;
`ifdef SIGNED_DIV_EN
      u_if.signed_mode = 1'b0;
`endif

      // Reset is held for two edges.
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_busy", W'(u_if.busy), W'(0));
      chk("rst_done", W'(u_if.done), W'(0));
      chk("rst_quot", u_if.quotient, '0);
      chk("rst_rem",  u_if.remainder, '0);
      chk("rst_dbz",  W'(u_if.div_by_zero), W'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_busy", W'(u_if.busy), W'(0));
      end

      // Directed operations
      run_op("u100_7",  32'd100,        32'd7,        1'b0, 1'b1);
      run_op("umax_1",  32'hFFFF_FFFF,  32'd1,        1'b0, 1'b1);
      run_op("u5_9",    32'd5,          32'd9,        1'b0, 1'b1);
      run_op("ubig",    32'hFFFF_FFFF,  32'h8000_0001, 1'b0, 1'b1);
      run_op("div0",    32'd1234,       32'd0,        1'b0, 1'b1);
      run_op("u8_2",    32'd8,          32'd2,        1'b0, 1'b1);

      // A start during RUN is ignored, and the outputs hold their earlier values.
      issue(32'd1000, 32'd10, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk("hold_quot", u_if.quotient, 32'd4);
      u_if.start    = 1'b1;
      u_if.dividend = 32'd77;
      u_if.divisor  = 32'd3;
      tick();
      u_if.start = 1'b0;
      wait_done(6, dc, bc);
      chk("ign_done_cycle", W'(dc), W'(W + 1));
      check_result("ign", 32'd1000, 32'd10, 1'b0);

      // Back-to-back: the second start is issued in the FIN cycle of the first operation.
      tick();
      issue(32'd999, 32'd4, 1'b0);
      wait_done(1, dc, bc);
      chk("b2b1_done_cycle", W'(dc), W'(W + 1));
      check_result("b2b1", 32'd999, 32'd4, 1'b0);
      run_op("b2b2", 32'd123456, 32'd321, 1'b0, 1'b1);

      // A reset during RUN aborts the operation.
      issue(32'd500, 32'd3, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", W'(u_if.busy), W'(0));
      chk("abort_quot", u_if.quotient, '0);
      chk("abort_rem",  u_if.remainder, '0);
      chk("abort_dbz",  W'(u_if.div_by_zero), W'(0));
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (u_if.done) cnt++;
         tick();
      end
      chk("abort_no_done", W'(cnt), W'(0));

`ifdef SIGNED_DIV_EN
      run_op("s_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1);
      run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      run_op("s_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1);
      run_op("s_div0",   32'hFFFF_FFF0, 32'd0,         1'b1, 1'b1);
`endif

      // Random operations, with a mix of divisor classes
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 4))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = 32'd1;
            3:       b = $urandom | 32'h8000_0000;
            default: b = $urandom;
         endcase
         s = 1'($urandom_range(0, 1));
         run_op("rand", a, b, s, ($urandom_range(0, 2) != 0));
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
